// File: rtl/router_pkt_src.sv
// Packet source for the 1x3 router: buffers a host payload, then sends header,
// payload and parity under busy back-pressure and samples the router error flag.
module router_pkt_src #(
    parameter int MAX_LEN = 63,
    parameter int ERR_WIN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dst_addr,
    input  logic [5:0] pay_len,
    input  logic       inj_bad_par,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       busy,
    input  logic       error,
    output logic       pkt_valid,
    output logic [7:0] data_in,
    output logic       cmd_err,
    output logic       tx_busy,
    output logic       done,
    output logic       pkt_err
);

    localparam int WW = $clog2(ERR_WIN + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        PARITY  = 3'd4,
        ERRWAIT = 3'd5
    } state_t;

    state_t          state_q;
    logic [1:0]      addr_q;
    logic [5:0]      len_q;
    logic            bad_q;
    logic [5:0]      idx_q;
    logic [7:0]      par_q;
    logic [WW-1:0]   win_q;
    logic            sticky_q;
    logic            s_ready_q;
    logic            pkt_valid_q;
    logic [7:0]      data_q;
    logic            cmd_err_q;
    logic            tx_busy_q;
    logic            done_q;
    logic            pkt_err_q;

    logic [7:0]      buf_q [MAX_LEN];
    logic            load_take_d;
    logic [5:0]      idx_nxt_d;
    logic            last_idx_d;
    logic            bad_cmd_d;

    assign load_take_d = (state_q == LOAD) && s_valid && s_ready_q;
    assign idx_nxt_d   = idx_q + 6'd1;
    assign last_idx_d  = (idx_q == len_q - 6'd1);
    assign bad_cmd_d   = (dst_addr == 2'd3) || (pay_len == 6'd0) || (int'(pay_len) > MAX_LEN);

    // Payload storage needs no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (load_take_d) begin
            buf_q[idx_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            bad_q       <= 1'b0;
            idx_q       <= 6'd0;
            par_q       <= 8'h00;
            win_q       <= '0;
            sticky_q    <= 1'b0;
            s_ready_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            data_q      <= 8'h00;
            cmd_err_q   <= 1'b0;
            tx_busy_q   <= 1'b0;
            done_q      <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            done_q    <= 1'b0;
            pkt_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (bad_cmd_d) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            addr_q    <= dst_addr;
                            len_q     <= pay_len;
                            bad_q     <= inj_bad_par;
                            idx_q     <= 6'd0;
                            par_q     <= 8'h00;
                            s_ready_q <= 1'b1;
                            tx_busy_q <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (load_take_d) begin
                        par_q <= par_q ^ s_data;
                        if (last_idx_d) begin
                            s_ready_q   <= 1'b0;
                            pkt_valid_q <= 1'b1;
                            data_q      <= {len_q, addr_q};
                            idx_q       <= 6'd0;
                            state_q     <= HEADER;
                        end else begin
                            idx_q <= idx_nxt_d;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        par_q   <= par_q ^ data_q;
                        data_q  <= buf_q[0];
                        state_q <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        if (last_idx_d) begin
                            pkt_valid_q <= 1'b0;
                            data_q      <= par_q ^ {8{bad_q}};
                            state_q     <= PARITY;
                        end else begin
                            idx_q  <= idx_nxt_d;
                            data_q <= buf_q[idx_nxt_d];
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data_q   <= 8'h00;
                        sticky_q <= 1'b0;
                        win_q    <= WW'(ERR_WIN - 1);
                        done_q   <= (ERR_WIN == 1);
                        state_q  <= ERRWAIT;
                    end
                end
                ERRWAIT: begin
                    // done is registered, so it is raised one edge before the final window cycle
                    if (win_q == '0) begin
                        tx_busy_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        if (win_q == WW'(1)) begin
                            done_q    <= 1'b1;
                            pkt_err_q <= sticky_q | error;
                        end
                        sticky_q <= sticky_q | error;
                        win_q    <= win_q - WW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign data_in   = data_q;
    assign cmd_err   = cmd_err_q;
    assign tx_busy   = tx_busy_q;
    assign done      = done_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Scoreboard bench for router_pkt_src: expected router bytes are queued when a
// packet is launched and popped as the router side accepts them.
module tb_router_pkt_src;

    localparam int ERR_WIN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dst_addr;
    logic [5:0] pay_len;
    logic       inj_bad_par;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       busy;
    logic       error;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       cmd_err;
    logic       tx_busy;
    logic       done;
    logic       pkt_err;

    router_pkt_src #(.MAX_LEN(63), .ERR_WIN(ERR_WIN)) dut (
        .clk(clk), .reset(reset), .start(start), .dst_addr(dst_addr),
        .pay_len(pay_len), .inj_bad_par(inj_bad_par), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .busy(busy), .error(error),
        .pkt_valid(pkt_valid), .data_in(data_in), .cmd_err(cmd_err),
        .tx_busy(tx_busy), .done(done), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] pay [64];
    int         cur_len, n_acc, gaps, hold_seen, err_cyc, done_cnt, done_base;
    int         err_at = -1;
    int         hold_left = 0;
    logic [7:0] hold_byte = 8'h00;
    bit         mon_en = 0, par_phase = 0, err_phase = 0, pkt_done = 0;
    bit         exp_perr = 0, rand_busy = 0;

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "_unexpected"}, 32'd1, 32'd0);
        else check_eq(tag, data_in, exp_q.pop_front());
    endtask

    // router-side monitor
    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (mon_en) begin
                if (n_acc >= 1 && n_acc <= cur_len && !pkt_valid) gaps++;
                if (pkt_valid && n_acc >= 1 && data_in == hold_byte) hold_seen++;
                if (err_phase) begin
                    err_cyc++;
                    if (err_cyc == 1) check_eq("errwait_data", data_in, 32'd0);
                    if (done) begin
                        check_eq("done_latency", err_cyc, ERR_WIN);
                        check_eq("pkt_err", pkt_err, exp_perr);
                        err_phase = 0;
                        pkt_done  = 1;
                    end
                end else if (par_phase) begin
                    if (!busy) begin
                        pop_check("parity");
                        check_eq("parity_valid", pkt_valid, 32'd0);
                        par_phase = 0;
                        err_phase = 1;
                        err_cyc   = 0;
                    end
                end else if (pkt_valid && !busy) begin
                    pop_check(n_acc == 0 ? "header" : "payload");
                    n_acc++;
                    if (n_acc == cur_len + 1) par_phase = 1;
                end
            end
        end
    end

    // router back-pressure and error driver
    initial begin
        busy  = 1'b0;
        error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_left > 0 && pkt_valid && n_acc >= 1 && data_in == hold_byte) begin
                busy = 1'b1;
                hold_left--;
            end else begin
                busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            error = err_phase && (err_cyc == err_at);
        end
    end

    task automatic start_pkt(input logic [1:0] a, input int len, input bit bad,
                             input bit fixed, input bit gappy, input int err);
        logic [7:0] hdr, p;
        logic [5:0] l6;
        bit took;
        l6  = len[5:0];
        hdr = {l6, a};
        p   = hdr;
        exp_q.delete();
        exp_q.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            if (!fixed) pay[i] = 8'($urandom);
            exp_q.push_back(pay[i]);
            p = p ^ pay[i];
        end
        if (bad) p = ~p;
        exp_q.push_back(p);
        cur_len   = len;
        n_acc     = 0;
        gaps      = 0;
        hold_seen = 0;
        par_phase = 0;
        err_phase = 0;
        pkt_done  = 0;
        err_at    = err;
        exp_perr  = (err >= 0) && (err < ERR_WIN - 1);
        done_base = done_cnt;
        mon_en    = 1;
        dst_addr = a; pay_len = l6; inj_bad_par = bad; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("tx_busy_after_start", tx_busy, 32'd1);
        for (int i = 0; i < len; i++) begin
            if (gappy && i > 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = pay[i];
            took    = 0;
            for (int t = 0; t < 50 && !took; t++) begin
                took = s_ready;
                @(posedge clk); #1;
            end
            if (!took) check_eq("load_timeout", 32'd0, 32'd1);
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_pkt(input int hold_exp);
        for (int t = 0; t < 3000 && !pkt_done; t++) @(posedge clk);
        check_eq("done_timeout", pkt_done, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("payload_gaps", gaps, 32'd0);
        check_eq("queue_left", exp_q.size(), 32'd0);
        check_eq("done_pulses", done_cnt - done_base, 32'd1);
        check_eq("tx_busy_idle", tx_busy, 32'd0);
        if (hold_exp > 0) check_eq("hold_cycles", hold_seen, hold_exp);
        mon_en = 0;
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
        dst_addr = a; pay_len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("cmd_err_pulse", cmd_err, 32'd1);
        check_eq("cmd_err_tx_busy", tx_busy, 32'd0);
        check_eq("cmd_err_s_ready", s_ready, 32'd0);
        @(posedge clk); #1;
        check_eq("cmd_err_single", cmd_err, 32'd0);
        check_eq("cmd_err_still_idle", tx_busy, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; dst_addr = 2'd0; pay_len = 6'd0;
        inj_bad_par = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {s_ready, pkt_valid, data_in, cmd_err, tx_busy, done, pkt_err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // basic packet, no back-pressure
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        start_pkt(2'd1, 3, 1'b0, 1'b1, 1'b0, -1);
        finish_pkt(0);

        // same packet with B2 held by busy for three cycles
        hold_byte = 8'hB2; hold_left = 3;
        start_pkt(2'd1, 3, 1'b0, 1'b1, 1'b0, -1);
        finish_pkt(4);
        hold_byte = 8'h00; hold_left = 0;

        bad_start(2'd3, 6'd5);
        bad_start(2'd0, 6'd0);

        // inverted parity and router error during the window
        pay[0] = 8'h55;
        start_pkt(2'd2, 1, 1'b1, 1'b1, 1'b0, 1);
        finish_pkt(0);

        // full-length payload with host gaps
        start_pkt(2'd3 - 2'd1, 63, 1'b0, 1'b0, 1'b1, -1);
        finish_pkt(0);

        // random back-pressure
        rand_busy = 1;
        start_pkt(2'd0, 10, 1'b0, 1'b0, 1'b0, -1);
        finish_pkt(0);
        rand_busy = 0;

        // reset during payload
        start_pkt(2'd0, 8, 1'b0, 1'b0, 1'b0, -1);
        for (int t = 0; t < 200 && n_acc < 3; t++) @(posedge clk);
        check_eq("reached_payload", n_acc >= 3, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("midpkt_reset_outputs", {s_ready, pkt_valid, data_in, cmd_err, tx_busy, done, pkt_err}, 32'd0);
        mon_en = 0;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (ERR_WIN + 12) @(posedge clk);
        #1;
        check_eq("no_done_after_reset", done_cnt - done_base, 32'd0);

        start_pkt(2'd2, 5, 1'b0, 1'b0, 1'b0, -1);
        finish_pkt(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
